dtu_bpss_cmpl: RTL and testbench

- Responder side of the DTU bypass descriptor path. Accepts the read and write bypass requests the DTU issues.
- Gates the matching host data streams so that only requested beats pass.
- Emits one completion-queue entry per request once all of its data beats have moved.
- Sits between the DTU bypass outputs/streams and the host DMA/CQ logic.

---
 rtl/dtu_cmpl_pkg.sv | 39 +++
 rtl/dtu_bpss_cmpl_if.sv | 38 +++
 rtl/dtu_cmpl_chan.sv | 135 +++++++++++++
 rtl/dtu_bpss_cmpl.sv | 101 ++++++++++
 tb/tb_dtu_bpss_cmpl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dtu_cmpl_pkg.sv
// Shared types and helpers for the DTU bypass completion responder.
// Field widths are fixed here; every file in the slice imports them.
package dtu_cmpl_pkg;

   localparam int LEN_BITS   = 28;
   localparam int PID_BITS   = 6;
   localparam int DEST_BITS  = 4;
   localparam int DATA_BITS  = 512;
   localparam int BEAT_BYTES = DATA_BITS / 8;
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

   typedef struct packed {
      logic [PID_BITS-1:0]  pid;
      logic [DEST_BITS-1:0] dest;
      logic                 last;
      logic                 is_wr;
   } cq_t;

   typedef struct packed {
      logic [LEN_BITS-1:0]  beats;
      logic [PID_BITS-1:0]  pid;
      logic [DEST_BITS-1:0] dest;
      logic                 last;
   } ost_entry_t;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_XFER,
      CH_CMPL
   } chan_state_t;

   // Shift plus round-up bit cannot overflow: the shifted value is far below 2**LEN_BITS-1.
   function automatic logic [LEN_BITS-1:0] beats_from_len(input logic [LEN_BITS-1:0] len);
      logic [LEN_BITS-1:0] mask;
      mask = LEN_BITS'(BEAT_BYTES - 1);
      return (len >> BEAT_SHIFT) + {{(LEN_BITS-1){1'b0}}, |(len & mask)};
   endfunction

endpackage

// File: rtl/dtu_bpss_cmpl_if.sv
// Bundles for the bypass request, data stream and completion-queue handshakes.
interface dtu_req_if;
   import dtu_cmpl_pkg::*;
   logic                 valid;
   logic                 ready;
   logic [LEN_BITS-1:0]  len;
   logic [PID_BITS-1:0]  pid;
   logic [DEST_BITS-1:0] dest;
   logic                 last;

   modport master (output valid, len, pid, dest, last, input ready);
   modport slave  (input valid, len, pid, dest, last, output ready);
endinterface

interface dtu_axis_if;
   import dtu_cmpl_pkg::*;
   logic                   tvalid;
   logic                   tready;
   logic [DATA_BITS-1:0]   tdata;
   logic [DATA_BITS/8-1:0] tkeep;
   logic                   tlast;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

interface dtu_cq_if;
   import dtu_cmpl_pkg::*;
   logic                 valid;
   logic                 ready;
   logic [PID_BITS-1:0]  pid;
   logic [DEST_BITS-1:0] dest;
   logic                 last;
   logic                 is_wr;

   modport master (output valid, pid, dest, last, is_wr, input ready);
   modport slave  (input valid, pid, dest, last, is_wr, output ready);
endinterface

// File: rtl/dtu_cmpl_chan.sv
// One bypass channel: outstanding-request FIFO, IDLE/XFER/CMPL FSM, beat
// counter and gating of the host data stream to exactly the requested beats.
module dtu_cmpl_chan
   import dtu_cmpl_pkg::*;
#(
   parameter  int N_OUTSTANDING = 8,
   localparam int CNT_W         = $clog2(N_OUTSTANDING) + 1
) (
   input  logic                 i_clk,
   input  logic                 i_srst,
   dtu_req_if.slave             req,
   dtu_axis_if.slave            s_axis,
   dtu_axis_if.master           m_axis,
   output logic                 o_cmpl_req,
   output logic [PID_BITS-1:0]  o_cmpl_pid,
   output logic [DEST_BITS-1:0] o_cmpl_dest,
   output logic                 o_cmpl_last,
   input  logic                 i_cmpl_ack,
   output logic [CNT_W-1:0]     o_outstanding
);

   localparam int PTR_W = $clog2(N_OUTSTANDING);

   ost_entry_t          r_mem [N_OUTSTANDING];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   chan_state_t         r_state;
   chan_state_t         w_state_next;
   ost_entry_t          r_cur;
   logic [LEN_BITS-1:0] r_beat_cnt;

   ost_entry_t w_head;
   logic       w_full;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   logic       w_xfer;
   logic       w_beat;
   logic       w_last_cnt;
   logic       w_final_beat;
   logic       w_load;
   logic       w_unused;

   assign w_full    = (r_count == CNT_W'(N_OUTSTANDING));
   assign w_empty   = (r_count == '0);
   assign w_head    = r_mem[r_rd_ptr];
   assign req.ready = !w_full && !i_srst;
   assign w_push    = req.valid && req.ready;

   // Incoming tlast is meaningless here; the beat count alone ends a request.
   assign w_unused = s_axis.tlast;

   assign w_xfer        = (r_state == CH_XFER) && !i_srst;
   assign w_last_cnt    = ((r_beat_cnt + LEN_BITS'(1)) == r_cur.beats);
   assign m_axis.tvalid = w_xfer && s_axis.tvalid;
   assign s_axis.tready = w_xfer && m_axis.tready;
   assign m_axis.tdata  = s_axis.tdata;
   assign m_axis.tkeep  = s_axis.tkeep;
   assign m_axis.tlast  = w_xfer && w_last_cnt;
   assign w_beat        = w_xfer && s_axis.tvalid && m_axis.tready;
   assign w_final_beat  = w_beat && w_last_cnt;

   // Data-carrying heads leave on their final beat, zero-length ones on completion.
   assign w_pop = w_final_beat ||
                  ((r_state == CH_CMPL) && i_cmpl_ack && (r_cur.beats == '0));

   assign o_cmpl_req    = (r_state == CH_CMPL) && !i_srst;
   assign o_cmpl_pid    = r_cur.pid;
   assign o_cmpl_dest   = r_cur.dest;
   assign o_cmpl_last   = r_cur.last;
   assign o_outstanding = i_srst ? '0 : r_count;

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      case (r_state)
         CH_IDLE: begin
            if (!w_empty) begin
               w_load       = 1'b1;
               w_state_next = (w_head.beats != '0) ? CH_XFER : CH_CMPL;
            end
         end
         CH_XFER: begin
            if (w_final_beat) begin
               w_state_next = CH_CMPL;
            end
         end
         CH_CMPL: begin
            if (i_cmpl_ack) begin
               w_state_next = CH_IDLE;
            end
         end
         default: w_state_next = CH_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= '{beats: beats_from_len(req.len), pid: req.pid,
                              dest: req.dest, last: req.last};
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_state    <= CH_IDLE;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_beat_cnt <= '0;
         r_cur      <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_W'(1);
         end
         if (w_load) begin
            r_cur      <= w_head;
            r_beat_cnt <= '0;
         end else if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + LEN_BITS'(1);
         end
      end
   end

endmodule

// File: rtl/dtu_bpss_cmpl.sv
// DTU bypass responder: two gated channels (rd, wr) feeding a single
// round-robin-arbitrated completion-queue output register.
module dtu_bpss_cmpl
   import dtu_cmpl_pkg::*;
#(
   parameter  int N_OUTSTANDING = 8,
   localparam int OCC_W         = $clog2(N_OUTSTANDING) + 1
) (
   input  logic             aclk,
   input  logic             areset,
   dtu_req_if.slave         s_rd_req,
   dtu_req_if.slave         s_wr_req,
   dtu_axis_if.slave        s_rd_axis,
   dtu_axis_if.master       m_rd_axis,
   dtu_axis_if.slave        s_wr_axis,
   dtu_axis_if.master       m_wr_axis,
   dtu_cq_if.master         m_cq,
   output logic [OCC_W-1:0] rd_outstanding,
   output logic [OCC_W-1:0] wr_outstanding
);

   logic [1:0]           w_req;
   logic [1:0]           w_grant;
   logic [PID_BITS-1:0]  w_pid  [2];
   logic [DEST_BITS-1:0] w_dest [2];
   logic [1:0]           w_last;
   logic                 w_load;
   cq_t                  w_cq_next;
   cq_t                  r_cq;
   logic                 r_cq_valid;
   logic                 r_ptr_wr;

   dtu_cmpl_chan #(.N_OUTSTANDING(N_OUTSTANDING)) u_rd_chan (
      .i_clk         (aclk),
      .i_srst        (areset),
      .req           (s_rd_req),
      .s_axis        (s_rd_axis),
      .m_axis        (m_rd_axis),
      .o_cmpl_req    (w_req[0]),
      .o_cmpl_pid    (w_pid[0]),
      .o_cmpl_dest   (w_dest[0]),
      .o_cmpl_last   (w_last[0]),
      .i_cmpl_ack    (w_grant[0]),
      .o_outstanding (rd_outstanding)
   );

   dtu_cmpl_chan #(.N_OUTSTANDING(N_OUTSTANDING)) u_wr_chan (
      .i_clk         (aclk),
      .i_srst        (areset),
      .req           (s_wr_req),
      .s_axis        (s_wr_axis),
      .m_axis        (m_wr_axis),
      .o_cmpl_req    (w_req[1]),
      .o_cmpl_pid    (w_pid[1]),
      .o_cmpl_dest   (w_dest[1]),
      .o_cmpl_last   (w_last[1]),
      .i_cmpl_ack    (w_grant[1]),
      .o_outstanding (wr_outstanding)
   );

   // Register takes a new entry when empty or when its current one drains this cycle.
   assign w_load = !r_cq_valid || m_cq.ready;

   always_comb begin
      w_grant   = 2'b00;
      w_cq_next = r_cq;
      if (w_load) begin
         if (w_req == 2'b11) begin
            w_grant = r_ptr_wr ? 2'b10 : 2'b01;
         end else begin
            w_grant = w_req;
         end
      end
      if (w_grant[1]) begin
         w_cq_next = '{pid: w_pid[1], dest: w_dest[1], last: w_last[1], is_wr: 1'b1};
      end else if (w_grant[0]) begin
         w_cq_next = '{pid: w_pid[0], dest: w_dest[0], last: w_last[0], is_wr: 1'b0};
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         r_cq_valid <= 1'b0;
         r_cq       <= '0;
         r_ptr_wr   <= 1'b0;
      end else if (w_load) begin
         r_cq_valid <= |w_grant;
         r_cq       <= w_cq_next;
         if (|w_grant) begin
            r_ptr_wr <= w_grant[0];
         end
      end
   end

   assign m_cq.valid = r_cq_valid && !areset;
   assign m_cq.pid   = r_cq.pid;
   assign m_cq.dest  = r_cq.dest;
   assign m_cq.last  = r_cq.last;
   assign m_cq.is_wr = r_cq.is_wr;

endmodule

// File: tb/tb_dtu_bpss_cmpl.sv
// Directed bench for dtu_bpss_cmpl: data gating, completion latency/order,
// backpressure, round-robin fairness and reset discard.
module tb_dtu_bpss_cmpl;
   import dtu_cmpl_pkg::*;

   logic       aclk = 1'b0;
   logic       areset = 1'b1;
   logic [3:0] rd_occ;
   logic [3:0] wr_occ;
   int         n_cmp = 0;
   int         n_bad = 0;
   cq_t        cq_q[$];

   always #5 aclk = ~aclk;

   dtu_req_if  rd_req ();
   dtu_req_if  wr_req ();
   dtu_axis_if s_rd ();
   dtu_axis_if m_rd ();
   dtu_axis_if s_wr ();
   dtu_axis_if m_wr ();
   dtu_cq_if   cq ();

   dtu_bpss_cmpl #(.N_OUTSTANDING(8)) dut (
      .aclk           (aclk),
      .areset         (areset),
      .s_rd_req       (rd_req),
      .s_wr_req       (wr_req),
      .s_rd_axis      (s_rd),
      .m_rd_axis      (m_rd),
      .s_wr_axis      (s_wr),
      .m_wr_axis      (m_wr),
      .m_cq           (cq),
      .rd_outstanding (rd_occ),
      .wr_outstanding (wr_occ)
   );

   always @(posedge aclk) begin
      cq_t e;
      if (!areset && cq.valid && cq.ready) begin
         e = '{pid: cq.pid, dest: cq.dest, last: cq.last, is_wr: cq.is_wr};
         cq_q.push_back(e);
         $display("cq   pid=%0d dest=%0d last=%0d is_wr=%0d", cq.pid, cq.dest, cq.last, cq.is_wr);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s = 0x%0h", tag, obs);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge aclk);
         #1;
      end
   endtask

   function automatic cq_t pop_cq();
      cq_t e;
      if (cq_q.size() == 0) e = '1;
      else e = cq_q.pop_front();
      return e;
   endfunction

   task automatic push_req(input bit is_wr, input logic [27:0] len, input logic [5:0] pid,
                           input logic [3:0] dest, input logic last);
      int budget = 50;
      if (is_wr) begin
         wr_req.valid = 1'b1; wr_req.len = len; wr_req.pid = pid;
         wr_req.dest = dest; wr_req.last = last;
      end else begin
         rd_req.valid = 1'b1; rd_req.len = len; rd_req.pid = pid;
         rd_req.dest = dest; rd_req.last = last;
      end
      while (!(is_wr ? wr_req.ready : rd_req.ready) && budget > 0) begin
         tick();
         budget--;
      end
      chk("req_accept", is_wr ? wr_req.ready : rd_req.ready, 1);
      tick();
      rd_req.valid = 1'b0;
      wr_req.valid = 1'b0;
   endtask

   // Drives one rd beat with the input tlast inverted, so a forwarded tlast would show.
   task automatic send_beat(input logic [63:0] data, input logic exp_last, input string tag);
      int budget = 50;
      s_rd.tvalid = 1'b1;
      s_rd.tdata  = {448'd0, data};
      s_rd.tlast  = !exp_last;
      while (!s_rd.tready && budget > 0) begin
         tick();
         budget--;
      end
      chk({tag, "_rdy"}, s_rd.tready, 1);
      chk({tag, "_data"}, m_rd.tdata[63:0], data);
      chk({tag, "_last"}, m_rd.tlast, exp_last);
      tick();
      s_rd.tvalid = 1'b0;
   endtask

   initial begin
      cq_t e;
      bit  seen;

      rd_req.valid = 0; rd_req.len = 0; rd_req.pid = 0; rd_req.dest = 0; rd_req.last = 0;
      wr_req.valid = 0; wr_req.len = 0; wr_req.pid = 0; wr_req.dest = 0; wr_req.last = 0;
      s_rd.tvalid = 0; s_rd.tdata = '0; s_rd.tkeep = '1; s_rd.tlast = 0;
      s_wr.tvalid = 0; s_wr.tdata = '0; s_wr.tkeep = '1; s_wr.tlast = 0;
      m_rd.tready = 1; m_wr.tready = 1; cq.ready = 1;

      // Reset state
      tick(3);
      chk("rst_rd_ready", rd_req.ready, 0);
      chk("rst_wr_ready", wr_req.ready, 0);
      chk("rst_cq_valid", cq.valid, 0);
      chk("rst_rd_occ", rd_occ, 0);
      chk("rst_wr_occ", wr_occ, 0);
      areset = 1'b0;
      tick();
      chk("post_rst_rd_ready", rd_req.ready, 1);
      chk("post_rst_wr_ready", wr_req.ready, 1);

      // A: 256-byte read = 4 beats, completion 2 cycles after the last beat
      push_req(0, 28'd256, 6'd3, 4'd1, 1'b0);
      chk("A_occ", rd_occ, 1);
      for (int i = 0; i < 4; i++) send_beat(64'(100 + i), i == 3, "A_beat");
      chk("A_occ_done", rd_occ, 0);
      chk("A_cq_lat1", cq.valid, 0);
      tick();
      chk("A_cq_valid", cq.valid, 1);
      chk("A_cq_pid", cq.pid, 3);
      chk("A_cq_dest", cq.dest, 1);
      chk("A_cq_is_wr", cq.is_wr, 0);
      tick(2);
      cq_q.delete();

      // B: zero-length write moves no data but still completes
      s_wr.tvalid = 1'b1;
      s_wr.tdata  = {448'd0, 64'hB0};
      seen = 0;
      push_req(1, 28'd0, 6'd9, 4'd2, 1'b1);
      repeat (6) begin
         if (s_wr.tready) seen = 1;
         tick();
      end
      chk("B_no_data", seen, 0);
      chk("B_cq_count", cq_q.size(), 1);
      e = pop_cq();
      chk("B_cq_pid", e.pid, 9);
      chk("B_cq_dest", e.dest, 2);
      chk("B_cq_flags", {e.is_wr, e.last}, 2'b11);
      s_wr.tvalid = 1'b0;
      cq_q.delete();

      // C: 65 bytes = 2 beats; the third beat stalls until a new request arrives
      push_req(0, 28'd65, 6'd5, 4'd3, 1'b0);
      send_beat(64'hC1, 1'b0, "C_beat1");
      send_beat(64'hC2, 1'b1, "C_beat2");
      s_rd.tvalid = 1'b1;
      s_rd.tdata  = {448'd0, 64'hC3};
      seen = 0;
      repeat (5) begin
         if (s_rd.tready || m_rd.tvalid) seen = 1;
         tick();
      end
      chk("C_stall", seen, 0);
      push_req(0, 28'd64, 6'd6, 4'd3, 1'b0);
      send_beat(64'hC3, 1'b1, "C_beat3");
      tick(4);
      chk("C_cq_count", cq_q.size(), 2);
      e = pop_cq();
      chk("C_cq0_pid", e.pid, 5);
      e = pop_cq();
      chk("C_cq1_pid", e.pid, 6);

      // D: fill the rd FIFO while CQ is blocked, then drain in order
      cq.ready = 1'b0;
      cq_q.delete();
      for (int i = 0; i < 8; i++) push_req(0, 28'd64, 6'(16 + i), 4'(i), 1'b0);
      chk("D_full_ready", rd_req.ready, 0);
      chk("D_occ", rd_occ, 8);
      rd_req.valid = 1'b1; rd_req.len = 28'd64; rd_req.pid = 6'd63;
      seen = 0;
      repeat (3) begin
         if (rd_req.ready) seen = 1;
         tick();
      end
      rd_req.valid = 1'b0;
      chk("D_ninth_blocked", seen, 0);
      cq.ready = 1'b1;
      for (int i = 0; i < 8; i++) send_beat(64'(8'hD0 + i), 1'b1, "D_beat");
      tick(5);
      chk("D_cq_count", cq_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         e = pop_cq();
         chk("D_cq_pid", e.pid, 64'(16 + i));
      end
      chk("D_occ_done", rd_occ, 0);

      // E: rd and wr contend; round robin must alternate starting with rd
      areset = 1'b1;
      tick(2);
      areset = 1'b0;
      tick();
      cq.ready = 1'b0;
      cq_q.delete();
      for (int i = 0; i < 4; i++) push_req(0, 28'd0, 6'(8'h20 + i), 4'd0, 1'b0);
      for (int i = 0; i < 4; i++) push_req(1, 28'd0, 6'(8'h30 + i), 4'd0, 1'b0);
      tick(6);
      chk("E_hold_valid", cq.valid, 1);
      chk("E_hold_head", {cq.is_wr, cq.pid}, {1'b0, 6'h20});
      chk("E_rd_occ", rd_occ, 3);
      chk("E_wr_occ", wr_occ, 4);
      tick(3);
      chk("E_hold_stable", {cq.valid, cq.is_wr, cq.pid}, {2'b10, 6'h20});
      cq.ready = 1'b1;
      tick(20);
      chk("E_cq_count", cq_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         e = pop_cq();
         chk("E_order", {e.is_wr, e.pid},
             (i % 2) ? {1'b1, 6'(8'h30 + i / 2)} : {1'b0, 6'(8'h20 + i / 2)});
      end

      // F: reset after 2 of 4 beats discards the request and its completion
      push_req(0, 28'd256, 6'd40, 4'd5, 1'b0);
      send_beat(64'hF0, 1'b0, "F_beat");
      send_beat(64'hF1, 1'b0, "F_beat");
      s_rd.tvalid = 1'b1;
      s_rd.tdata  = {448'd0, 64'hF2};
      areset = 1'b1;
      #1;
      chk("F_rst_tready", s_rd.tready, 0);
      chk("F_rst_m_tvalid", m_rd.tvalid, 0);
      chk("F_rst_req_ready", rd_req.ready, 0);
      chk("F_rst_cq_valid", cq.valid, 0);
      chk("F_rst_occ", rd_occ, 0);
      tick(2);
      areset = 1'b0;
      cq_q.delete();
      seen = 0;
      repeat (10) begin
         if (s_rd.tready || cq.valid) seen = 1;
         tick();
      end
      s_rd.tvalid = 1'b0;
      chk("F_no_activity", seen, 0);
      chk("F_no_cq", cq_q.size(), 0);
      chk("F_occ_after", rd_occ, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
